// File: rtl/dbf_fine_apod.sv
// Fine-delay linear interpolator with per-channel apodisation for one beamformer channel.
// A fraction LUT, stepped once per accepted sample, supplies the sub-sample delay for each output.
module dbf_fine_apod #(
  parameter int INPUT_WD  = 14,
  parameter int FRAC_WD   = 4,
  parameter int APO_WD    = 16,
  parameter int ADDR_WD   = 10,
  parameter int FD_OUT_WD = 19
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tx_en,
  input  logic                        start,
  input  logic signed [INPUT_WD-1:0]  din,
  input  logic                        din_valid,
  input  logic signed [APO_WD-1:0]    apo_din,
  input  logic        [ADDR_WD-1:0]   lut_addr,
  input  logic        [FRAC_WD-1:0]   lut_din,
  input  logic                        lut_we,
  output logic signed [FD_OUT_WD-1:0] fd_dout,
  output logic                        fd_dout_valid,
  output logic signed [31:0]          dbf_dout,
  output logic                        dbf_dout_valid
);

  localparam int DIFF_WD   = INPUT_WD + 1;
  localparam int PROD_WD   = FD_OUT_WD + APO_WD;
  localparam int LUT_DEPTH = 1 << ADDR_WD;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [ADDR_WD-1:0] PTR_MAX = '1;

  logic [FRAC_WD-1:0] lut_mem [LUT_DEPTH];

  logic [1:0]                  state_q, state_d;
  logic [ADDR_WD-1:0]          rd_ptr_q, rd_ptr_d;
  logic signed [INPUT_WD-1:0]  x_prev_q, x_prev_d;
  logic                        accept;

  logic                        s1_v_q;
  logic signed [FD_OUT_WD-1:0] s1_base_q;
  logic signed [DIFF_WD-1:0]   s1_diff_q;
  logic        [FRAC_WD-1:0]   s1_frac_q;

  logic                        s2_v_q;
  logic signed [FD_OUT_WD-1:0] s2_base_q;
  logic signed [FD_OUT_WD-1:0] s2_prod_q;

  logic                        fd_v_q;
  logic signed [FD_OUT_WD-1:0] fd_q;
  logic                        dbf_v_q;
  logic signed [31:0]          dbf_q;

  logic signed [DIFF_WD-1:0]   diff_d;
  logic signed [FD_OUT_WD-1:0] base_d;
  logic signed [FD_OUT_WD-1:0] diff_ext;
  logic signed [FD_OUT_WD-1:0] frac_ext;
  logic signed [FD_OUT_WD-1:0] prod_d;
  logic signed [FD_OUT_WD-1:0] fd_d;
  logic signed [PROD_WD-1:0]   p_d;
  logic signed [31:0]          dbf_d;

  assign accept = din_valid && !tx_en && start &&
                  ((state_q == S_RUN) || (state_q == S_HOLD));

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    x_prev_d = x_prev_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          rd_ptr_d = '0;
          x_prev_d = '0;
        end
      end
      S_RUN: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (accept) begin
          x_prev_d = din;
          // The last LUT entry is reused for the rest of the line instead of wrapping.
          if (rd_ptr_q == PTR_MAX) begin
            state_d = S_HOLD;
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_WD'(1);
          end
        end
      end
      S_HOLD: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (accept) begin
          x_prev_d = din;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // x_prev*2^F + (din-x_prev)*frac, split across two stages; every term fits FD_OUT_WD.
  always_comb begin
    diff_d   = DIFF_WD'(din) - DIFF_WD'(x_prev_q);
    base_d   = FD_OUT_WD'(x_prev_q) <<< FRAC_WD;
    diff_ext = FD_OUT_WD'(s1_diff_q);
    frac_ext = FD_OUT_WD'(s1_frac_q);
    prod_d   = diff_ext * frac_ext;
    fd_d     = s2_base_q + s2_prod_q;
    p_d      = PROD_WD'(fd_q) * PROD_WD'(apo_din);
    dbf_d    = 32'(p_d >>> 3);
  end

  always_ff @(posedge clk) begin
    if (lut_we) begin
      lut_mem[lut_addr] <= lut_din;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      rd_ptr_q  <= '0;
      x_prev_q  <= '0;
      s1_v_q    <= 1'b0;
      s1_base_q <= '0;
      s1_diff_q <= '0;
      s1_frac_q <= '0;
      s2_v_q    <= 1'b0;
      s2_base_q <= '0;
      s2_prod_q <= '0;
      fd_v_q    <= 1'b0;
      fd_q      <= '0;
      dbf_v_q   <= 1'b0;
      dbf_q     <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      x_prev_q <= x_prev_d;

      // Read-first: a write to the same address this edge is not yet visible.
      s1_v_q <= accept;
      if (accept) begin
        s1_base_q <= base_d;
        s1_diff_q <= diff_d;
        s1_frac_q <= lut_mem[rd_ptr_q];
      end

      s2_v_q    <= s1_v_q && start;
      s2_base_q <= s1_base_q;
      s2_prod_q <= prod_d;

      fd_v_q <= s2_v_q && start;
      fd_q   <= fd_d;

      dbf_v_q <= fd_v_q && start;
      dbf_q   <= dbf_d;
    end
  end

  always_comb begin
    fd_dout_valid  = fd_v_q;
    fd_dout        = fd_v_q ? fd_q : '0;
    dbf_dout_valid = dbf_v_q;
    dbf_dout       = dbf_v_q ? dbf_q : '0;
  end

endmodule

// File: tb/tb_dbf_fine_apod.sv
// Scoreboard bench for dbf_fine_apod: the driver queues expected (cycle, value) pairs,
// a negedge monitor pops them as the DUT raises its output valids.
module tb_dbf_fine_apod;

  localparam int IW  = 14;
  localparam int FW  = 4;
  localparam int AW  = 16;
  localparam int ADW = 10;
  localparam int OW  = 19;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 tx_en;
  logic                 start;
  logic signed [IW-1:0] din;
  logic                 din_valid;
  logic signed [AW-1:0] apo_din;
  logic [ADW-1:0]       lut_addr;
  logic [FW-1:0]        lut_din;
  logic                 lut_we;
  logic signed [OW-1:0] fd_dout;
  logic                 fd_dout_valid;
  logic signed [31:0]   dbf_dout;
  logic                 dbf_dout_valid;

  dbf_fine_apod #(
    .INPUT_WD (IW),
    .FRAC_WD  (FW),
    .APO_WD   (AW),
    .ADDR_WD  (ADW),
    .FD_OUT_WD(OW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_en         (tx_en),
    .start         (start),
    .din           (din),
    .din_valid     (din_valid),
    .apo_din       (apo_din),
    .lut_addr      (lut_addr),
    .lut_din       (lut_din),
    .lut_we        (lut_we),
    .fd_dout       (fd_dout),
    .fd_dout_valid (fd_dout_valid),
    .dbf_dout      (dbf_dout),
    .dbf_dout_valid(dbf_dout_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int v;
  } exp_t;

  exp_t q_fd[$];
  exp_t q_dbf[$];
  int   total = 0;
  int   bad   = 0;
  int   lut_m[1024];
  int   xm;
  int   ptr_m;
  int   apo_m;

  function automatic void chk(string nm, longint act, longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q_fd.size() > 0 && q_fd[0].c < cyc) begin
      e = q_fd.pop_front();
      chk("fd_missing", cyc, e.c);
    end
    if (fd_dout_valid) begin
      if (q_fd.size() == 0) begin
        chk("fd_unexpected_valid", fd_dout_valid, 0);
      end else begin
        e = q_fd.pop_front();
        chk("fd_latency", cyc, e.c);
        chk("fd_value", fd_dout, e.v);
      end
    end else begin
      chk("fd_idle_zero", fd_dout, 0);
    end

    if (q_dbf.size() > 0 && q_dbf[0].c < cyc) begin
      e = q_dbf.pop_front();
      chk("dbf_missing", cyc, e.c);
    end
    if (dbf_dout_valid) begin
      if (q_dbf.size() == 0) begin
        chk("dbf_unexpected_valid", dbf_dout_valid, 0);
      end else begin
        e = q_dbf.pop_front();
        chk("dbf_latency", cyc, e.c);
        chk("dbf_value", dbf_dout, e.v);
      end
    end else begin
      chk("dbf_idle_zero", dbf_dout, 0);
    end
  end

  task automatic go();
    @(negedge clk);
  endtask

  task automatic push(input int efd, input int edbf);
    exp_t e;
    e.c = cyc + 3;
    e.v = efd;
    q_fd.push_back(e);
    e.c = cyc + 4;
    e.v = edbf;
    q_dbf.push_back(e);
  endtask

  // Anything scheduled after the next edge is cancelled by start falling or reset.
  task automatic flush();
    while (q_fd.size() > 0 && q_fd[$].c > cyc) void'(q_fd.pop_back());
    while (q_dbf.size() > 0 && q_dbf[$].c > cyc) void'(q_dbf.pop_back());
  endtask

  task automatic send(input int d, input int efd, input int edbf);
    din_valid = 1'b1;
    din       = IW'(d);
    push(efd, edbf);
    xm = d;
    go();
  endtask

  task automatic send_m(input int d);
    int     f;
    int     fd;
    longint p;
    f  = lut_m[ptr_m];
    fd = xm * 16 + (d - xm) * f;
    p  = longint'(fd) * longint'(apo_m);
    send(d, fd, int'(p >>> 3));
    if (ptr_m < 1023) ptr_m++;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) go();
  endtask

  task automatic line_begin(input int apo);
    apo_m     = apo;
    apo_din   = AW'(apo);
    start     = 1'b1;
    din_valid = 1'b0;
    go();
    xm    = 0;
    ptr_m = 0;
  endtask

  task automatic line_end();
    start     = 1'b0;
    din_valid = 1'b0;
    flush();
    go();
  endtask

  task automatic lut_wr(input int a, input int v);
    lut_we   = 1'b1;
    lut_addr = ADW'(a);
    lut_din  = FW'(v);
    lut_m[a] = v;
    go();
    lut_we = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; tx_en = 1'b0; din_valid = 1'b0; din = '0;
    apo_din = '0; lut_we = 1'b0; lut_addr = '0; lut_din = '0;
    xm = 0; ptr_m = 0; apo_m = 0;
    go();
    chk("reset_fd_dout", fd_dout, 0);
    chk("reset_fd_valid", fd_dout_valid, 0);
    chk("reset_dbf_dout", dbf_dout, 0);
    chk("reset_dbf_valid", dbf_dout_valid, 0);
    rst_n = 1'b0;
    go();

    // Nominal: frac 8 is half-sample interpolation.
    lut_wr(0, 8); lut_wr(1, 8); lut_wr(2, 8);
    line_begin(16384);
    send(100, 800, 1638400);
    send(100, 1600, 3276800);
    send(200, 2400, 4915200);
    idle(6);
    line_end();

    // Full-scale swings with the largest fraction.
    lut_wr(0, 15); lut_wr(1, 15); lut_wr(2, 15);
    line_begin(16384);
    send(-8192, -122880, -251658240);
    send(8191, 114673, 234850304);
    send(-8192, -114689, -234883072);
    idle(6);
    line_end();

    // Samples during transmit are dropped without moving the pointer or x_prev.
    line_begin(16384);
    tx_en = 1'b1;
    repeat (5) begin
      din_valid = 1'b1; din = IW'(500); go();
      din_valid = 1'b0; go();
    end
    tx_en = 1'b0;
    send(100, 1500, 3072000);
    idle(6);
    line_end();

    // Abort by start falling with samples in flight, then restart.
    lut_wr(3, 5);
    line_begin(16384);
    send(10, 150, 307200);
    send(20, 310, 634880);
    send(30, 470, 962560);
    line_end();
    idle(8);
    line_begin(16384);
    send(40, 600, 1228800);
    idle(6);
    line_end();

    // Reset pulsed mid-line.
    line_begin(16384);
    send(1, 15, 30720);
    send(2, 31, 63488);
    send(3, 47, 96256);
    send(4, 53, 108544);
    din_valid = 1'b0;
    chk("pre_reset_fd_valid", fd_dout_valid, 1);
    chk("pre_reset_dbf_valid", dbf_dout_valid, 1);
    #2 rst_n = 1'b1;
    #1;
    chk("midline_reset_fd_dout", fd_dout, 0);
    chk("midline_reset_fd_valid", fd_dout_valid, 0);
    chk("midline_reset_dbf_dout", dbf_dout, 0);
    chk("midline_reset_dbf_valid", dbf_dout_valid, 0);
    flush();
    go();
    go();
    rst_n = 1'b0;
    go();
    xm = 0; ptr_m = 0;
    send(7, 105, 215040);
    idle(6);
    line_end();

    // LUT write colliding with the read of the same address.
    lut_wr(0, 1); lut_wr(1, 2); lut_wr(2, 3); lut_wr(3, 4); lut_wr(4, 9);
    line_begin(8);
    send(16, 16, 16);
    send(32, 288, 288);
    send(48, 560, 560);
    send(64, 832, 832);
    lut_we = 1'b1; lut_addr = ADW'(4); lut_din = FW'(3);
    send(80, 1168, 1168);
    lut_we = 1'b0;
    lut_m[4] = 3;
    idle(6);
    line_end();
    line_begin(-8);
    send(16, 16, -16);
    send(32, 288, -288);
    send(48, 560, -560);
    send(64, 832, -832);
    send(80, 1072, -1072);
    idle(6);
    line_end();

    // Pointer saturation across a full LUT sweep plus three extra samples.
    for (int i = 0; i < 1024; i++) lut_wr(i, (i * 7) % 16);
    line_begin(-12345);
    for (int i = 0; i < 1027; i++) send_m(((i * 37) % 2000) - 1000);
    idle(6);
    line_end();
    idle(4);

    chk("fd_queue_drained", q_fd.size(), 0);
    chk("dbf_queue_drained", q_dbf.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
